output_ram_writer: RTL

OUTPUT_RAM_WRITER -- requirements
Module: output_ram_writer

---
 rtl/output_ram_writer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/output_ram_writer.sv
// Frame writer: accepts one raster-order frame of 256x256 pixels into an internal
// frame memory, with an independent registered readback port and a frame counter.
`timescale 1ns/1ps

module output_ram_writer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iStart,
    input  logic                  iValid,
    input  logic [DATA_WIDTH-1:0] iData,
    output logic                  oReady,
    input  logic [7:0]            iRdCol,
    input  logic [7:0]            iRdRow,
    output logic [DATA_WIDTH-1:0] oRdData,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [7:0]            oFrameCount,
    output logic [1:0]            oState
);

    // Handshake: a pixel moves on a rising edge where iValid=1 and oReady=1.
    // oReady is high for the whole WRITE state and never depends on iValid.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [7:0]            col_q;
    logic [7:0]            col_d;
    logic [7:0]            row_q;
    logic [7:0]            row_d;
    logic [7:0]            frame_cnt_q;
    logic [7:0]            frame_cnt_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  xfer;
    logic                  last_px;

    logic [DATA_WIDTH-1:0] mem [0:65535];

    assign xfer    = iValid && (state_q == ST_WRITE);
    assign last_px = (col_q == 8'hFF) && (row_q == 8'hFF);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_WRITE;
                    col_d   = 8'd0;
                    row_d   = 8'd0;
                end
            end
            ST_WRITE: begin
                if (xfer) begin
                    if (last_px) begin
                        // Counter bumps on entry so it is already visible during DONE.
                        state_d     = ST_DONE;
                        col_d       = 8'd0;
                        row_d       = 8'd0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                        if (col_q == 8'hFF) begin
                            row_d = row_q + 8'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                col_d   = 8'd0;
                row_d   = 8'd0;
                state_d = iStart ? ST_WRITE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                col_d   = 8'd0;
                row_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            col_q       <= 8'd0;
            row_q       <= 8'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Memory has no reset; a read of the address being written returns the old word.
    always_ff @(posedge clock) begin
        if (xfer) begin
            mem[{row_q, col_q}] <= iData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[{iRdRow, iRdCol}];
        end
    end

    assign oReady      = (state_q == ST_WRITE);
    assign oBusy       = (state_q == ST_WRITE);
    assign oDone       = (state_q == ST_DONE);
    assign oFrameCount = frame_cnt_q;
    assign oRdData     = rd_data_q;
    assign oState      = state_q;

endmodule
